// File: rtl/lcis_pkg.sv
// Shared types for the LCIS order dispatcher: the order record and the FSM state.
package lcis_pkg;

    // Default address width of an order record.
    localparam int LCIS_ADDR_W = 16;

    // One compute order as the host presents it.
    typedef struct packed {
        logic [LCIS_ADDR_W-1:0] start;
        logic [LCIS_ADDR_W-1:0] len;
        logic [LCIS_ADDR_W-1:0] back;
    } order_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE,
        REPORT
    } disp_state_e;

endpackage

// File: rtl/order_fifo.sv
// Synchronous FIFO of order records; pointers wrap modulo DEPTH (power of two).
module order_fifo
    import lcis_pkg::*;
#(
    parameter type T     = order_t,
    parameter int  DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  T                       din,
    output T                       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    T              r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    // A full FIFO drops pushes; a pop on an empty FIFO is ignored.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/lcis_order_dispatcher.sv
// Queues host orders and issues them one at a time to the LCIS engine, reporting completion.
module lcis_order_dispatcher
    import lcis_pkg::*;
#(
    parameter int ADDR_WIDTH    = 16,
    parameter int DEPTH         = 4,
    parameter int START_TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_WIDTH-1:0]  req_start,
    input  logic [ADDR_WIDTH-1:0]  req_len,
    input  logic [ADDR_WIDTH-1:0]  req_back,
    output logic                   order_valid,
    output logic [ADDR_WIDTH-1:0]  order_start,
    output logic [ADDR_WIDTH-1:0]  order_len,
    output logic [ADDR_WIDTH-1:0]  order_back,
    input  logic                   order_busy,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  done_back,
    output logic                   done_err,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   idle
);

    // The timer counts WAIT_START cycles 0..START_TIMEOUT-1.
    localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] start;
        logic [ADDR_WIDTH-1:0] len;
        logic [ADDR_WIDTH-1:0] back;
    } entry_t;

    entry_t                w_req;
    entry_t                w_head;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [$clog2(DEPTH):0] w_count;

    disp_state_e           r_state;
    disp_state_e           w_state_nxt;
    logic [TW-1:0]         r_timer;
    logic [TW-1:0]         w_timer_nxt;
    logic                  w_load;
    logic                  w_done_nxt;
    logic                  w_done_err_nxt;
    logic [ADDR_WIDTH-1:0] w_done_back_nxt;

    logic                  r_order_valid;
    logic [ADDR_WIDTH-1:0] r_order_start;
    logic [ADDR_WIDTH-1:0] r_order_len;
    logic [ADDR_WIDTH-1:0] r_order_back;
    logic                  r_done;
    logic                  r_done_err;
    logic [ADDR_WIDTH-1:0] r_done_back;

    assign w_req  = '{start: req_start, len: req_len, back: req_back};
    assign w_push = req_valid && req_ready;

    order_fifo #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_req),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Next-state, FIFO pop and next values of the registered outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_pop           = 1'b0;
        w_load          = 1'b0;
        w_done_nxt      = 1'b0;
        w_done_err_nxt  = 1'b0;
        w_done_back_nxt = r_done_back;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head.len == '0) begin
                        // Empty orders are never sent to the engine; report them as skipped.
                        w_state_nxt     = REPORT;
                        w_done_nxt      = 1'b1;
                        w_done_err_nxt  = 1'b1;
                        w_done_back_nxt = w_head.back;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                w_timer_nxt = '0;
                w_state_nxt = WAIT_START;
            end
            WAIT_START: begin
                if (order_busy) begin
                    w_state_nxt = WAIT_DONE;
                end else if (r_timer == TW'(START_TIMEOUT - 1)) begin
                    w_state_nxt     = REPORT;
                    w_done_nxt      = 1'b1;
                    w_done_err_nxt  = 1'b1;
                    w_done_back_nxt = r_order_back;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            WAIT_DONE: begin
                // The engine may run arbitrarily long; only busy falling ends the order.
                if (!order_busy) begin
                    w_state_nxt     = REPORT;
                    w_done_nxt      = 1'b1;
                    w_done_back_nxt = r_order_back;
                end
            end
            REPORT: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, timer and registered engine/host outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            r_order_valid <= 1'b0;
            r_order_start <= '0;
            r_order_len   <= '0;
            r_order_back  <= '0;
            r_done        <= 1'b0;
            r_done_err    <= 1'b0;
            r_done_back   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_order_valid <= (w_state_nxt == ISSUE);
            r_done        <= w_done_nxt;
            r_done_err    <= w_done_err_nxt;
            r_done_back   <= w_done_back_nxt;
            if (w_load) begin
                r_order_start <= w_head.start;
                r_order_len   <= w_head.len;
                r_order_back  <= w_head.back;
            end
        end
    end

    assign req_ready   = !w_full;
    assign pending     = w_count;
    assign idle        = w_empty && (r_state == IDLE);
    assign order_valid = r_order_valid;
    assign order_start = r_order_start;
    assign order_len   = r_order_len;
    assign order_back  = r_order_back;
    assign done        = r_done;
    assign done_err    = r_done_err;
    assign done_back   = r_done_back;

endmodule

// File: tb/tb_lcis_order_dispatcher.sv
// Scoreboard bench for lcis_order_dispatcher with a behavioural LCIS engine stub.
`timescale 1ns/1ps
module tb_lcis_order_dispatcher;

    localparam int AW    = 16;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_start = '0;
    logic [AW-1:0] req_len = '0;
    logic [AW-1:0] req_back = '0;
    logic          order_valid;
    logic [AW-1:0] order_start;
    logic [AW-1:0] order_len;
    logic [AW-1:0] order_back;
    logic          order_busy = 1'b0;
    logic          done;
    logic [AW-1:0] done_back;
    logic          done_err;
    logic [CW-1:0] pending;
    logic          idle;

    always #5 clk = ~clk;

    lcis_order_dispatcher #(
        .ADDR_WIDTH    (AW),
        .DEPTH         (DEPTH),
        .START_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_start   (req_start),
        .req_len     (req_len),
        .req_back    (req_back),
        .order_valid (order_valid),
        .order_start (order_start),
        .order_len   (order_len),
        .order_back  (order_back),
        .order_busy  (order_busy),
        .done        (done),
        .done_back   (done_back),
        .done_err    (done_err),
        .pending     (pending),
        .idle        (idle)
    );

    typedef struct { logic [AW-1:0] start; logic [AW-1:0] len; logic [AW-1:0] back; } iss_t;
    typedef struct { logic [AW-1:0] back; logic err; } dn_t;

    // Reference model: orders accepted by the FIFO, in acceptance order.
    iss_t        issue_q[$];
    dn_t         done_q[$];
    bit          mute_q[$];
    logic [15:0] mem [256];
    int          eng_hold = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every issue and every completion must match the head of the model queues.
    iss_t e_iss;
    dn_t  e_dn;
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (order_valid) begin
                check("ov_one_cycle", prev_ov, 0);
                if (issue_q.size() == 0) begin
                    check("unexpected_issue", 1, 0);
                end else begin
                    e_iss = issue_q.pop_front();
                    check("issue_start", order_start, e_iss.start);
                    check("issue_len", order_len, e_iss.len);
                    check("issue_back", order_back, e_iss.back);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e_dn = done_q.pop_front();
                    check("done_back", done_back, e_dn.back);
                    check("done_err", done_err, e_dn.err);
                end
            end
            check("ready_vs_full", req_ready, (pending != DEPTH));
        end
        prev_ov = rst_n ? order_valid : 1'b0;
    end

    // Engine stub: on each issue, optionally raise busy after 0..2 cycles, run, write the LCIS length.
    initial begin : engine
        bit          m;
        int          d, h, best, run;
        logic [15:0] s, l, b;
        forever begin
            @(negedge clk);
            if (rst_n && order_valid) begin
                m = (mute_q.size() > 0) ? mute_q.pop_front() : 1'b0;
                s = order_start; l = order_len; b = order_back;
                if (!m) begin
                    d = $urandom_range(0, 2);
                    h = (eng_hold > 0) ? eng_hold : $urandom_range(1, 4);
                    @(posedge clk);
                    repeat (d) @(posedge clk);
                    #1 order_busy = 1'b1;
                    repeat (h) @(posedge clk);
                    best = 0; run = 0;
                    for (int i = 0; i < int'(l); i++) begin
                        if (i > 0 && mem[8'(s + i)] > mem[8'(s + i - 1)]) run++;
                        else run = 1;
                        if (run > best) best = run;
                    end
                    mem[8'(b)] = 16'(best);
                    #1 order_busy = 1'b0;
                end
            end
        end
    end

    // Drive one request cycle; entered and left at posedge+1.
    task automatic push(input logic [AW-1:0] s, input logic [AW-1:0] l, input logic [AW-1:0] b,
                        input bit m, output bit acc);
        req_valid = 1'b1; req_start = s; req_len = l; req_back = b;
        @(negedge clk);
        acc = req_ready;
        @(posedge clk);
        if (acc) begin
            if (l != 0) begin
                issue_q.push_back('{s, l, b});
                mute_q.push_back(m);
            end
            done_q.push_back('{b, (l == 0) || m});
        end
        #1 req_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin @(posedge clk); #1; n++; end
        check(name, done, 1);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (!(done_q.size() == 0 && idle === 1'b1 && order_busy === 1'b0) && n < budget) begin
            @(posedge clk); #1; n++;
        end
        check(name, (done_q.size() == 0) && (idle === 1'b1), 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit acc;
        int n;
        logic [AW-1:0] s, l, b;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 15));
        mem[1] = 1; mem[2] = 3; mem[3] = 5; mem[4] = 4; mem[5] = 7;

        // Reset values while rst_n is held low.
        #2;
        check("rst_order_valid", order_valid, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_idle", idle, 1);
        check("rst_pending", pending, 0);
        check("rst_done", {done, done_err}, 0);
        check("rst_done_back", done_back, 0);
        check("rst_order_data", {order_start, order_len, order_back}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        idle_cycles(1);

        // Single order, real LCIS result, 2-cycle issue latency.
        push(1, 5, 0, 0, acc);
        check("t1_accept", acc, 1);
        check("t1_no_early_issue", order_valid, 0);
        idle_cycles(1);
        check("t1_issue_latency", order_valid, 1);
        wait_done("t1_done", 40);
        drain("t1_drain", 40);
        check("t1_lcis_result", mem[0], 3);

        // Zero-length order: skipped, reported 2 cycles after push.
        push(0, 0, 7, 0, acc);
        check("t3_no_early_done", done, 0);
        idle_cycles(1);
        check("t3_done_latency", done, 1);
        check("t3_no_issue", order_valid, 0);
        drain("t3_drain", 20);

        // Start timeout on a silent engine, then a normal order queued behind it.
        push(40, 3, 9, 1, acc);
        push(50, 2, 10, 0, acc);
        check("tmo_issue_cycle", order_valid, 1);
        idle_cycles(TMO);
        check("tmo_not_early", done, 0);
        idle_cycles(1);
        check("tmo_done_cycle", done, 1);
        check("tmo_done_err", done_err, 1);
        drain("tmo_drain", 60);

        // Fill the FIFO behind a long order, then push while full.
        eng_hold = 40;
        push(30, 4, 20, 0, acc);
        idle_cycles(4);
        eng_hold = 0;
        check("full_pre_pending", pending, 0);
        for (int i = 0; i < 4; i++) push(AW'(1 + 5 * i), 5, AW'(100 + i), 0, acc);
        check("full_pending", pending, DEPTH);
        check("full_ready_low", req_ready, 0);
        push(99, 3, 99, 0, acc);
        check("full_push_dropped", acc, 0);
        drain("full_drain", 300);
        check("full_idle", idle, 1);
        check("full_pending_zero", pending, 0);

        // Push in the same cycle the FSM pops, at pending == DEPTH-1.
        eng_hold = 30;
        push(60, 4, 30, 0, acc);
        idle_cycles(4);
        eng_hold = 0;
        for (int i = 0; i < DEPTH - 1; i++) push(AW'(70 + i), 3, AW'(31 + i), 0, acc);
        check("pp_pre_pending", pending, DEPTH - 1);
        wait_done("pp_first_done", 60);
        idle_cycles(1);
        push(80, 3, 40, 0, acc);
        check("pp_accept", acc, 1);
        check("pp_pending_same", pending, DEPTH - 1);
        drain("pp_drain", 300);

        // Asynchronous reset during WAIT_DONE with orders queued.
        eng_hold = 20;
        push(90, 4, 50, 0, acc);
        push(91, 4, 51, 0, acc);
        push(92, 4, 52, 0, acc);
        eng_hold = 0;
        n = 0;
        while (order_busy !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        check("rst_busy_seen", order_busy, 1);
        idle_cycles(2);
        #3 rst_n = 1'b0;
        #1;
        issue_q.delete(); done_q.delete(); mute_q.delete();
        check("mid_rst_order_valid", order_valid, 0);
        check("mid_rst_pending", pending, 0);
        check("mid_rst_idle", idle, 1);
        check("mid_rst_ready", req_ready, 1);
        check("mid_rst_done", done, 0);
        idle_cycles(2);
        rst_n = 1'b1;
        n = 0;
        while (order_busy !== 1'b0 && n < 40) begin @(posedge clk); #1; n++; end
        check("post_rst_engine_free", order_busy, 0);
        push(100, 2, 60, 0, acc);
        wait_done("post_rst_done", 40);
        drain("post_rst_drain", 40);

        // Randomized traffic against the queue model.
        for (int k = 0; k < 40; k++) begin
            idle_cycles($urandom_range(0, 3));
            s = AW'($urandom_range(0, 200));
            l = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom_range(1, 6));
            b = AW'($urandom_range(0, 255));
            push(s, l, b, ($urandom_range(0, 7) == 0), acc);
        end
        drain("rand_drain", 2000);
        check("final_issue_q_empty", issue_q.size(), 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
